// File: rtl/addr_sequencer.sv
// addr_sequencer: prescaled up/down/one-shot address stepper; ping-pong mode 10 built only with ADDR_SEQUENCER_PINGPONG_EN
module addr_sequencer #(
  parameter int WIDTH = 5,
  parameter int MAX = 31,
  parameter int TICK_DIV = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] addr,
  output logic             tick,
  output logic             wrap,
  output logic             done
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [WIDTH-1:0] MAXW = WIDTH'(MAX);
  logic [PW-1:0] pre;
  logic step, one, pp, pp_up, down, term, nxt_term, wrap_n, done_n;
  logic [WIDTH-1:0] nxt;
  assign step = enable && (pre == PW'(TICK_DIV - 1));
  assign one = mode == 2'b01;
`ifdef ADDR_SEQUENCER_PINGPONG_EN
  assign pp = mode == 2'b10;
  always_ff @(posedge clock)
    if (reset || load) pp_up <= 1'b1;
    else if (step && pp && term) pp_up <= ~pp_up;
`else
  assign pp = 1'b0;
  assign pp_up = 1'b1;
`endif
  always_comb begin
    down = pp ? ~pp_up : dir;
    term = down ? (addr == '0) : (addr >= MAXW);
    nxt = !term ? (down ? addr - WIDTH'(1) : addr + WIDTH'(1))
        : one ? addr
        : pp ? (down ? WIDTH'(1) : MAXW - WIDTH'(1))
        : (down ? MAXW : '0);
    nxt_term = down ? (nxt == '0) : (nxt >= MAXW);
    wrap_n = term && !one;
    done_n = done || (one && nxt_term);
  end
  always_ff @(posedge clock)
    if (reset) begin
      addr <= '0;
      pre <= '0;
      tick <= 1'b0;
      wrap <= 1'b0;
      done <= 1'b0;
    end else if (load) begin
      addr <= (load_value > MAXW) ? MAXW : load_value;
      pre <= '0;
      tick <= 1'b0;
      wrap <= 1'b0;
      done <= 1'b0;
    end else begin
      tick <= step;
      wrap <= step && wrap_n;
      if (enable) pre <= step ? '0 : pre + PW'(1);
      if (step) begin
        addr <= nxt;
        done <= done_n;
      end
    end
endmodule

// File: tb/tb_addr_sequencer.sv
// tb_addr_sequencer: directed vector table plus hand sequences for addr_sequencer
module tb_addr_sequencer;
  logic clock = 1'b0, reset = 1'b1, enable = 1'b0, dir = 1'b0, load = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [4:0] load_value = '0;
  logic [4:0] addr, addr2, addr3;
  logic tick, wrap, done, tick2, wrap2, done2, tick3, wrap3, done3;
  int checks = 0, failures = 0;
  always #5 clock = ~clock;
  addr_sequencer dut (.clock(clock), .reset(reset), .enable(enable), .dir(dir), .mode(mode),
    .load(load), .load_value(load_value), .addr(addr), .tick(tick), .wrap(wrap), .done(done));
  addr_sequencer #(.WIDTH(5), .MAX(3), .TICK_DIV(1)) dut2 (.clock(clock), .reset(reset),
    .enable(enable), .dir(dir), .mode(mode), .load(load), .load_value(load_value),
    .addr(addr2), .tick(tick2), .wrap(wrap2), .done(done2));
  addr_sequencer #(.WIDTH(5), .MAX(20), .TICK_DIV(8)) dut3 (.clock(clock), .reset(reset),
    .enable(enable), .dir(dir), .mode(mode), .load(load), .load_value(load_value),
    .addr(addr3), .tick(tick3), .wrap(wrap3), .done(done3));
  typedef struct {
    logic ld; logic [4:0] lv; logic en; logic dr; logic [1:0] md; int n;
    logic [4:0] a; logic t; logic w; logic d;
  } vec_t;
  vec_t v[$];
  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  logic [4:0] pp_a[8];
  logic pp_w[8];
  initial begin
    v.push_back('{1'b0, 5'd0,  1'b1, 1'b0, 2'd0, 7,   5'd0,  1'b0, 1'b0, 1'b0});
    v.push_back('{1'b0, 5'd0,  1'b1, 1'b0, 2'd0, 1,   5'd1,  1'b1, 1'b0, 1'b0});
    v.push_back('{1'b0, 5'd0,  1'b1, 1'b0, 2'd0, 1,   5'd1,  1'b0, 1'b0, 1'b0});
    v.push_back('{1'b0, 5'd0,  1'b1, 1'b0, 2'd0, 239, 5'd31, 1'b1, 1'b0, 1'b0});
    v.push_back('{1'b0, 5'd0,  1'b1, 1'b0, 2'd0, 8,   5'd0,  1'b1, 1'b1, 1'b0});
    v.push_back('{1'b0, 5'd0,  1'b1, 1'b0, 2'd0, 1,   5'd0,  1'b0, 1'b0, 1'b0});
    v.push_back('{1'b0, 5'd0,  1'b1, 1'b0, 2'd0, 4,   5'd0,  1'b0, 1'b0, 1'b0});
    v.push_back('{1'b0, 5'd0,  1'b0, 1'b0, 2'd0, 20,  5'd0,  1'b0, 1'b0, 1'b0});
    v.push_back('{1'b0, 5'd0,  1'b1, 1'b0, 2'd0, 2,   5'd0,  1'b0, 1'b0, 1'b0});
    v.push_back('{1'b0, 5'd0,  1'b1, 1'b0, 2'd0, 1,   5'd1,  1'b1, 1'b0, 1'b0});
    v.push_back('{1'b0, 5'd0,  1'b1, 1'b1, 2'd0, 8,   5'd0,  1'b1, 1'b0, 1'b0});
    v.push_back('{1'b0, 5'd0,  1'b1, 1'b1, 2'd0, 8,   5'd31, 1'b1, 1'b1, 1'b0});
    v.push_back('{1'b0, 5'd0,  1'b1, 1'b1, 2'd0, 8,   5'd30, 1'b1, 1'b0, 1'b0});
    v.push_back('{1'b0, 5'd0,  1'b1, 1'b1, 2'd0, 7,   5'd30, 1'b0, 1'b0, 1'b0});
    v.push_back('{1'b1, 5'd10, 1'b1, 1'b1, 2'd0, 1,   5'd10, 1'b0, 1'b0, 1'b0});
    v.push_back('{1'b0, 5'd0,  1'b1, 1'b1, 2'd0, 7,   5'd10, 1'b0, 1'b0, 1'b0});
    v.push_back('{1'b0, 5'd0,  1'b1, 1'b1, 2'd0, 1,   5'd9,  1'b1, 1'b0, 1'b0});
    v.push_back('{1'b1, 5'd28, 1'b1, 1'b0, 2'd1, 1,   5'd28, 1'b0, 1'b0, 1'b0});
    v.push_back('{1'b0, 5'd0,  1'b1, 1'b0, 2'd1, 8,   5'd29, 1'b1, 1'b0, 1'b0});
    v.push_back('{1'b0, 5'd0,  1'b1, 1'b0, 2'd1, 8,   5'd30, 1'b1, 1'b0, 1'b0});
    v.push_back('{1'b0, 5'd0,  1'b1, 1'b0, 2'd1, 8,   5'd31, 1'b1, 1'b0, 1'b1});
    v.push_back('{1'b0, 5'd0,  1'b1, 1'b0, 2'd1, 40,  5'd31, 1'b1, 1'b0, 1'b1});
    v.push_back('{1'b1, 5'd0,  1'b1, 1'b0, 2'd1, 1,   5'd0,  1'b0, 1'b0, 1'b0});
    v.push_back('{1'b0, 5'd0,  1'b1, 1'b0, 2'd1, 8,   5'd1,  1'b1, 1'b0, 1'b0});
    v.push_back('{1'b0, 5'd0,  1'b1, 1'b1, 2'd1, 8,   5'd0,  1'b1, 1'b0, 1'b1});
    v.push_back('{1'b0, 5'd0,  1'b1, 1'b1, 2'd1, 8,   5'd0,  1'b1, 1'b0, 1'b1});
    v.push_back('{1'b0, 5'd0,  1'b1, 1'b1, 2'd0, 8,   5'd31, 1'b1, 1'b1, 1'b1});
`ifdef ADDR_SEQUENCER_PINGPONG_EN
    pp_a = '{5'd1, 5'd2, 5'd3, 5'd2, 5'd1, 5'd0, 5'd1, 5'd2};
    pp_w = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
`else
    pp_a = '{5'd1, 5'd2, 5'd3, 5'd0, 5'd1, 5'd2, 5'd3, 5'd0};
    pp_w = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
`endif
    enable = 1'b1;
    cyc(2);
    chk("reset", {addr, tick, wrap, done}, 8'h00);
    reset = 1'b0;
    for (int i = 0; i < v.size(); i++) begin
      load = v[i].ld; load_value = v[i].lv; enable = v[i].en; dir = v[i].dr; mode = v[i].md;
      cyc(v[i].n);
      chk($sformatf("vec%0d {addr,tick,wrap,done}", i), {addr, tick, wrap, done},
          {v[i].a, v[i].t, v[i].w, v[i].d});
    end
    load = 1'b1; load_value = 5'd31; enable = 1'b0; mode = 2'd0;
    cyc(1);
    chk("load31 max31", {3'b0, addr}, 8'd31);
    chk("load31 clamp max20", {3'b0, addr3}, 8'd20);
    load = 1'b0; reset = 1'b1;
    cyc(1);
    reset = 1'b0; enable = 1'b1; dir = 1'b1;
    cyc(8);
    chk("down from reset 0->31", {addr, tick, wrap, done}, {5'd31, 3'b110});
    cyc(8);
    chk("down 31->30", {addr, tick, wrap, done}, {5'd30, 3'b100});
    cyc(7);
    reset = 1'b1;
    cyc(1);
    chk("reset over step", {addr, tick, wrap, done}, 8'h00);
    chk("pingpong reset", {3'b0, addr2}, 8'd0);
    reset = 1'b0; mode = 2'b10; dir = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      chk($sformatf("pingpong step%0d {addr,wrap}", i), {2'b0, addr2, wrap2}, {2'b0, pp_a[i], pp_w[i]});
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/addr_sequencer.md
Name: addr_sequencer

Overview:
- Parametrised address sequencer that produces a memory read/write address stepping at a programmable slow rate.
- Successor to the fixed 5-bit free-running address counter.
- Replaces the gated/divided clock with a clock-enable prescaler, so all logic runs on `clock`.
- Adds configurable width and terminal count, up/down direction, parallel load, one-shot mode and wrap/done status. It drives RAM address ports and display scanners in the lab designs.

Parameters:
- WIDTH, 5: address width in bits.
- MAX, 31: terminal address. Must satisfy 1 <= MAX <= 2^WIDTH-1.
- TICK_DIV, 8: clock cycles per step. Use 8 for simulation and 33_554_432 for the board demo. TICK_DIV = 1 means one step every enabled cycle.

Ports:
- clock  in  1  system clock, all state on posedge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  run. Low freezes the prescaler and the address.
- dir  in  1  0 = count up, 1 = count down. Ignored in ping-pong mode.
- mode  in  2  00 = wrap, 01 = one-shot, 10 = ping-pong (macro-dependent), 11 = treated as wrap.
- load  in  1  synchronous parallel-load strobe.
- load_value  in  WIDTH  value loaded into addr.
- addr  out  WIDTH  current address (registered).
- tick  out  1  one-cycle pulse, high in the cycle addr shows a newly stepped value.
- wrap  out  1  one-cycle pulse, high in the cycle addr shows a wrapped or turnaround value.
- done  out  1  sticky; one-shot has reached its terminal address.

Behaviour:
- Reset (sampled on posedge clock):
  - addr = 0, prescaler = 0, tick = 0, wrap = 0, done = 0.
  - Internal ping-pong direction = up.
  - Reset overrides every other input.
- Prescaler:
  - Width is clog2(TICK_DIV), minimum 1 bit.
  - Increments only when enable = 1.
  - step = enable && (prescaler == TICK_DIV-1). On step the prescaler returns to 0.
- Priority per edge: reset > load > step > hold.
- Load:
  - addr <= min(load_value, MAX); prescaler <= 0; done <= 0.
  - Ping-pong direction <= up.
  - tick = 0 and wrap = 0 in the following cycle.
  - Load is accepted regardless of enable.
- Step, applied at the same edge the prescaler returns to 0:
  - Wrap mode, up: addr == MAX -> 0 with wrap = 1; otherwise addr + 1.
  - Wrap mode, down: addr == 0 -> MAX with wrap = 1; otherwise addr - 1.
  - addr > MAX (only possible if MAX changes between builds, never at runtime) is treated as terminal.
  - One-shot mode:
    - Up: steps toward MAX. Down: steps toward 0.
    - On the step that lands on the terminal value, done <= 1.
    - Further steps hold addr and do not pulse wrap. tick still pulses.
    - done clears only on reset or load.
- tick and wrap are registered. Each is high for exactly one cycle, aligned with the updated addr value.
- Latency: with enable held high from reset release, the first addr change appears TICK_DIV cycles later.
- Deasserting enable:
  - Mid-count freezes the prescaler value.
  - Re-asserting enable resumes counting without restarting the period.
- A change of dir or mode takes effect at the next step. No state is cleared.
- A change of mode does not clear done.
- Arithmetic is modulo 2^WIDTH internally. Terminal compares use MAX, never 2^WIDTH-1.

Optional Feature:
- Macro: ADDR_SEQUENCER_PINGPONG_EN.
- Defined:
  - mode 10 bounces between 0 and MAX.
  - An internal direction flag replaces dir.
  - At MAX while going up: next value MAX-1, flag flips to down, wrap pulses.
  - At 0 while going down: next value 1, flag flips to up, wrap pulses.
  - MAX == 1 alternates 0,1,0,1 with wrap on every step.
- Not defined:
  - No direction flag is built.
  - mode 10 behaves exactly as mode 00 (wrap).

Test Plan:
- Wrap, up, enable = 1, TICK_DIV = 8, MAX = 31, after 2 reset cycles:
  - addr goes 0 -> 1 at cycle 8.
  - addr reaches 31 at cycle 248 and returns to 0 at cycle 256 with wrap = 1 for that single cycle.
  - tick = 1 every 8th cycle.
- Wrap, down from reset -> addr sequence 0, 31, 30, …, with wrap = 1 on the 0 -> 31 transition.
- Enable gating:
  - Drop enable at prescaler = 5, hold 20 cycles -> addr and prescaler unchanged.
  - Re-raise enable -> next step after 3 more cycles.
- Load:
  - load_value = 10 coincident with a step -> addr = 10, prescaler = 0, no tick/wrap.
  - load_value = 31 with MAX = 20 -> addr = 20.
- One-shot:
  - Up from load 28, MAX = 31 -> 29, 30, 31, then done = 1.
  - addr holds at 31 over 5 further steps with no wrap.
  - Load 0 clears done.
  - Reset asserted mid-count -> all outputs 0 on the next edge.
- Ping-pong with macro, MAX = 3:
  - addr 0, 1, 2, 3, 2, 1, 0, 1, with wrap on the steps to 2 (from 3) and to 1 (from 0).
  - Without macro, the same stimulus gives 0, 1, 2, 3, 0.
